bp_me_burst_mem_responder: RTL



---
 rtl/bp_me_burst_mem_responder_pkg.sv | 76 +++++++
 rtl/bp_me_burst_mem_responder_ram.sv | 27 ++
 rtl/bp_me_burst_mem_responder.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/bp_me_burst_mem_responder_pkg.sv
// Shared types for the BedRock burst memory responder.
// BP_ME_MEM_RESP_DELAY_EN adds the e_delay response state.
package bp_me_pkg;

  localparam int paddr_width_p     = 40;
  localparam int lce_id_width_p    = 4;
  localparam int lce_assoc_p       = 8;
  localparam int cce_block_width_p = 512;

  localparam int lg_lce_assoc_lp   = $clog2(lce_assoc_p);
  localparam int block_beats_lp    = cce_block_width_p / 64;
  localparam int beat_cnt_width_lp = $clog2(block_beats_lp) + 1;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bp_bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1  = 3'd0,
    e_bedrock_msg_size_2  = 3'd1,
    e_bedrock_msg_size_4  = 3'd2,
    e_bedrock_msg_size_8  = 3'd3,
    e_bedrock_msg_size_16 = 3'd4,
    e_bedrock_msg_size_32 = 3'd5,
    e_bedrock_msg_size_64 = 3'd6
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    logic [lg_lce_assoc_lp-1:0] way_id;
    logic [lce_id_width_p-1:0]  lce_id;
  } bp_bedrock_mem_payload_s;

  typedef struct packed {
    bp_bedrock_mem_payload_s  payload;
    bp_bedrock_msg_size_e     size;
    logic [paddr_width_p-1:0] addr;
    logic [3:0]               subop;
    bp_bedrock_mem_type_e     msg_type;
  } bp_bedrock_mem_header_s;

  localparam int cce_mem_msg_header_width_lp = $bits(bp_bedrock_mem_header_s);

  typedef enum logic [2:0] {
    e_reset,
    e_ready,
    e_wr_data,
`ifdef BP_ME_MEM_RESP_DELAY_EN
    e_delay,
`endif
    e_resp_header,
    e_rd_data
  } bp_me_mem_responder_state_e;

  function automatic logic [beat_cnt_width_lp-1:0] beats_minus1(
    input logic [2:0] size
  );
    logic [beat_cnt_width_lp-1:0] one;
    one = beat_cnt_width_lp'(1);
    if (size > 3'd3) return (one << (size - 3'd3)) - one;
    return '0;
  endfunction

  function automatic logic is_rd(input bp_bedrock_mem_type_e t);
    return (t == e_bedrock_mem_rd) || (t == e_bedrock_mem_uc_rd);
  endfunction

  function automatic logic is_wr(input bp_bedrock_mem_type_e t);
    return (t == e_bedrock_mem_wr) || (t == e_bedrock_mem_uc_wr);
  endfunction

endpackage

// File: rtl/bp_me_burst_mem_responder_ram.sv
// Byte-masked 64-bit RAM with asynchronous read.
// Contents survive reset.
module bp_me_burst_mem_responder_ram #(
  parameter  int els_p     = 1024,
  localparam int lg_els_lp = $clog2(els_p)
) (
  input  logic                 clk_i,
  input  logic                 w_v_i,
  input  logic [lg_els_lp-1:0] addr_i,
  input  logic [7:0]           w_mask_i,
  input  logic [63:0]          w_data_i,
  output logic [63:0]          r_data_o
);

  logic [63:0] mem [els_p];

  always_ff @(posedge clk_i) begin
    if (w_v_i) begin
      for (int b = 0; b < 8; b++) begin
        if (w_mask_i[b]) mem[addr_i][8*b +: 8] <= w_data_i[8*b +: 8];
      end
    end
  end

  assign r_data_o = mem[addr_i];

endmodule

// File: rtl/bp_me_burst_mem_responder.sv
// BedRock burst memory-side responder backed by a dword RAM model.
// Define BP_ME_MEM_RESP_DELAY_EN to add a delay_p-cycle response delay.
module bp_me_burst_mem_responder
  import bp_me_pkg::*;
#(
  parameter int mem_els_p = 1024,
  parameter int delay_p   = 4
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic [cce_mem_msg_header_width_lp-1:0] mem_cmd_header_i,
  input  logic                                   mem_cmd_header_v_i,
  output logic                                   mem_cmd_header_ready_and_o,
  input  logic [63:0]                            mem_cmd_data_i,
  input  logic                                   mem_cmd_data_v_i,
  output logic                                   mem_cmd_data_ready_and_o,
  output logic [cce_mem_msg_header_width_lp-1:0] mem_resp_header_o,
  output logic                                   mem_resp_header_v_o,
  input  logic                                   mem_resp_header_ready_and_i,
  output logic [63:0]                            mem_resp_data_o,
  output logic                                   mem_resp_data_v_o,
  input  logic                                   mem_resp_data_ready_and_i
);

  localparam int lg_els_lp = $clog2(mem_els_p);

  bp_me_mem_responder_state_e state_q, state_d;
  bp_bedrock_mem_header_s hdr_q, hdr_d, cmd_hdr;
  logic [beat_cnt_width_lp-1:0] cnt_q, cnt_d, last_cnt;
  logic [lg_els_lp-1:0] w0, wrap_mask, ram_addr;
  logic [7:0] size_mask, w_mask;
  logic [5:0] w_shift;
  logic [63:0] w_data;
  logic ram_w, go_resp, sub_dword;

`ifdef BP_ME_MEM_RESP_DELAY_EN
  localparam int dly_width_lp = $clog2(delay_p + 2);
  logic [dly_width_lp-1:0] dly_q, dly_d;
`else
  logic unused_delay;
  assign unused_delay = ^delay_p;
`endif

  assign cmd_hdr  = mem_cmd_header_i;
  assign last_cnt = beats_minus1(hdr_q.size);

  // Critical-word-first: wrap inside the size-aligned block
  assign w0        = hdr_q.addr[3 +: lg_els_lp];
  assign wrap_mask = lg_els_lp'(last_cnt);
  assign ram_addr  = (w0 & ~wrap_mask)
                   | ((w0 + lg_els_lp'(cnt_q)) & wrap_mask);

  assign sub_dword = hdr_q.size < e_bedrock_msg_size_8;

  always_comb begin
    size_mask = 8'hff;
    unique case (1'b1)
      hdr_q.size == e_bedrock_msg_size_1: size_mask = 8'h01;
      hdr_q.size == e_bedrock_msg_size_2: size_mask = 8'h03;
      hdr_q.size == e_bedrock_msg_size_4: size_mask = 8'h0f;
      default:                            size_mask = 8'hff;
    endcase
  end

  assign w_shift = sub_dword ? {hdr_q.addr[2:0], 3'b000} : 6'd0;
  assign w_mask  = sub_dword ? (size_mask << hdr_q.addr[2:0]) : 8'hff;
  assign w_data  = mem_cmd_data_i << w_shift;

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    cnt_d   = cnt_q;
    ram_w   = 1'b0;
    go_resp = 1'b0;
    mem_cmd_header_ready_and_o = 1'b0;
    mem_cmd_data_ready_and_o   = 1'b0;
    mem_resp_header_v_o        = 1'b0;
    mem_resp_data_v_o          = 1'b0;
`ifdef BP_ME_MEM_RESP_DELAY_EN
    dly_d = dly_q;
`endif
    case (state_q)
      e_reset: state_d = e_ready;
      e_ready: begin
        mem_cmd_header_ready_and_o = 1'b1;
        if (mem_cmd_header_v_i) begin
          hdr_d = cmd_hdr;
          cnt_d = '0;
          if (is_wr(cmd_hdr.msg_type)) state_d = e_wr_data;
          else go_resp = 1'b1;
        end
      end
      e_wr_data: begin
        mem_cmd_data_ready_and_o = 1'b1;
        if (mem_cmd_data_v_i) begin
          ram_w = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == last_cnt) go_resp = 1'b1;
        end
      end
`ifdef BP_ME_MEM_RESP_DELAY_EN
      e_delay: begin
        if (dly_q <= dly_width_lp'(1)) state_d = e_resp_header;
        else dly_d = dly_q - 1'b1;
      end
`endif
      e_resp_header: begin
        mem_resp_header_v_o = 1'b1;
        if (mem_resp_header_ready_and_i) begin
          cnt_d   = '0;
          state_d = is_rd(hdr_q.msg_type) ? e_rd_data : e_ready;
        end
      end
      e_rd_data: begin
        mem_resp_data_v_o = 1'b1;
        if (mem_resp_data_ready_and_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == last_cnt) state_d = e_ready;
        end
      end
      default: state_d = e_reset;
    endcase
    if (go_resp) begin
`ifdef BP_ME_MEM_RESP_DELAY_EN
      if (delay_p != 0) begin
        state_d = e_delay;
        dly_d   = dly_width_lp'(delay_p);
      end else begin
        state_d = e_resp_header;
      end
`else
      state_d = e_resp_header;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_reset;
      hdr_q   <= '0;
      cnt_q   <= '0;
`ifdef BP_ME_MEM_RESP_DELAY_EN
      dly_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      cnt_q   <= cnt_d;
`ifdef BP_ME_MEM_RESP_DELAY_EN
      dly_q   <= dly_d;
`endif
    end
  end

  assign mem_resp_header_o = hdr_q;

  bp_me_burst_mem_responder_ram #(
    .els_p (mem_els_p)
  ) ram (
    .clk_i    (clk_i),
    .w_v_i    (ram_w),
    .addr_i   (ram_addr),
    .w_mask_i (w_mask),
    .w_data_i (w_data),
    .r_data_o (mem_resp_data_o)
  );

endmodule
